// File: rtl/stop_it_pkg.sv
// stop_it_pkg: shared types and constants for the Stop-It game controller.
//   state_e            - controller state encoding (IDLE, ARM, RUN, WON, LOST)
//   DEFAULT_WIDTH      - default count/target width (matches the time counter)
//   DEFAULT_COUNT_MAX  - last count value at the default width
//   DEFAULT_ARM_CYCLES - default length of the arming delay in game-clock cycles
//   count_max()        - largest count representable in a given width
package stop_it_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RUN  = 3'd2,
    WON  = 3'd3,
    LOST = 3'd4
  } state_e;

  localparam int DEFAULT_WIDTH      = 5;
  localparam int DEFAULT_COUNT_MAX  = (1 << DEFAULT_WIDTH) - 1;
  localparam int DEFAULT_ARM_CYCLES = 8;

  function automatic int count_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/stop_it_controller_rising_edge.sv
// rising_edge: one-cycle pulse on the rising edge of a synchronized level.
//   clk   - clock
//   rst   - synchronous active-high reset
//   in    - input level (already debounced and synchronized)
//   pulse - high for the one cycle where in is high and was low last cycle
// The history register resets to 1 so a level held high through reset does
// not look like a fresh press once reset is released.
module rising_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= in;
    end
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/stop_it_controller.sv
// stop_it_controller: game-control FSM for the Stop-It game.
// Latches a random target on a start press, holds the time counter in reset
// for ARM_CYCLES cycles, then lets it count and judges the stop press
// against the target.
//   clk_4_i        - 4 Hz game clock (shared with the time counter)
//   rst_i          - synchronous active-high reset
//   start_i        - start button level
//   stop_i         - stop button level
//   random_i       - free-running random value, sampled as the new target
//   count_i        - current count from the time counter
//   counter_en_o   - enable to the time counter
//   counter_rst_no - active-low reset to the time counter
//   target_o       - latched target for display
//   win_o / lose_o - result indicators
// Optional build macro STOP_IT_BLINK_EN: result indicators blink (toggle every
// cycle, starting high) while in WON/LOST; otherwise they are steady.
module stop_it_controller
  import stop_it_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int ARM_CYCLES = DEFAULT_ARM_CYCLES
) (
  input  logic             clk_4_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [WIDTH-1:0] random_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             counter_en_o,
  output logic             counter_rst_no,
  output logic [WIDTH-1:0] target_o,
  output logic             win_o,
  output logic             lose_o
);

  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(count_max(WIDTH));
  localparam logic [7:0]       ARM_LAST  = 8'(ARM_CYCLES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] target_q;
  logic [7:0]       arm_q;
  logic             start_edge;
  logic             stop_edge;
  logic             at_max;

  rising_edge u_start_edge (
    .clk   (clk_4_i),
    .rst   (rst_i),
    .in    (start_i),
    .pulse (start_edge)
  );

  rising_edge u_stop_edge (
    .clk   (clk_4_i),
    .rst   (rst_i),
    .in    (stop_i),
    .pulse (stop_edge)
  );

  assign at_max = (count_i == COUNT_MAX);

  always_ff @(posedge clk_4_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      arm_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            target_q <= random_i;
            arm_q    <= '0;
            state_q  <= ARM;
          end
        end
        ARM: begin
          arm_q <= arm_q + 8'd1;
          // An early press loses even on the last arming cycle.
          if (stop_edge) begin
            state_q <= LOST;
          end else if (arm_q == ARM_LAST) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          // The press is judged before the timeout so a press on the last
          // count is still honoured.
          if (stop_edge) begin
            state_q <= (count_i == target_q) ? WON : LOST;
          end else if (at_max) begin
            state_q <= LOST;
          end
        end
        WON, LOST: begin
          if (start_edge) begin
            target_q <= random_i;
            arm_q    <= '0;
            state_q  <= ARM;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Enable drops in the cycle the game is decided, so the counter freezes
  // on the judged value and never wraps past COUNT_MAX.
  assign counter_en_o   = (state_q == RUN) & ~stop_edge & ~at_max;
  assign counter_rst_no = ~((state_q == IDLE) | (state_q == ARM));
  assign target_o       = target_q;

`ifdef STOP_IT_BLINK_EN
  logic blink_q;

  // Held clear outside the result states, so the first WON/LOST cycle
  // always shows the indicator high.
  always_ff @(posedge clk_4_i) begin
    if (rst_i) begin
      blink_q <= 1'b0;
    end else if ((state_q == WON) || (state_q == LOST)) begin
      blink_q <= ~blink_q;
    end else begin
      blink_q <= 1'b0;
    end
  end

  assign win_o  = (state_q == WON)  & ~blink_q;
  assign lose_o = (state_q == LOST) & ~blink_q;
`else
  assign win_o  = (state_q == WON);
  assign lose_o = (state_q == LOST);
`endif

endmodule
